// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer controller: FSM state encoding,
// SPI mode constants, default word width / clock divider and bit counter width.
// No ports; imported by spi_bit_cnt and spi_xfer_ctrl.
package spi_pkg;

  // SPI mode 0: sclk idles low, data sampled on the rising edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_CLK_DIV = 2;

  // Bit counter width; covers DATA_W up to 16.
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_HIGH   = 3'd2,
    ST_LOW    = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

endpackage

// File: rtl/spi_bit_cnt.sv
// Loadable down counter that paces the shift, with a zero flag (NOR of all bits).
// Latency: cnt/zero update one clk after load/dec. Priority rst > dec > load > hold.
// Ports: clk, rst (sync, active high), load, dec, din -> cnt, zero.
module spi_bit_cnt
  import spi_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] din,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (dec) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else if (load) begin
      cnt_d = din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = ~|cnt_q;

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI mode-0 master sequencer: one DATA_W-bit word per start, MSB first.
// Latency: done pulses (2*DATA_W+2)*CLK_DIV+1 posedges after the accept edge.
// Backpressure: start is ignored while busy; a new start may be taken in the done cycle.
// Ports: clk, rst (sync, active high), start, tx_data -> rx_data, busy, done;
//        SPI pins sclk, mosi, cs_n out, miso in.
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  state_e            state_q;
  logic [DIV_W-1:0]  div_q;
  logic [DATA_W-1:0] tx_shift_q;
  logic [DATA_W-1:0] rx_shift_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              sclk_q;
  logic              mosi_q;
  logic              cs_n_q;
  logic              busy_q;
  logic              done_q;
  // FINISH spans two phases: a trailing sclk-low half period, then the cs_n hold.
  logic              fin_hold_q;

  logic              phase_end;
  logic              accept;
  logic              cnt_dec;
  logic              cnt_zero;
  logic [CNT_W-1:0]  cnt_val;

  assign phase_end = (div_q == '0);
  assign accept    = (state_q == ST_IDLE) && start;
  assign cnt_dec   = (state_q == ST_HIGH) && phase_end && !cnt_zero;

  spi_bit_cnt u_bit_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .dec  (cnt_dec),
    .din  (CNT_W'(DATA_W - 1)),
    .cnt  (cnt_val),
    .zero (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      sclk_q     <= SPI_CPOL;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fin_hold_q <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Phase divider runs in every state except IDLE.
      if (state_q != ST_IDLE) begin
        div_q <= phase_end ? DIV_LAST : div_q - DIV_W'(1);
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            tx_shift_q <= tx_data;
            mosi_q     <= tx_data[DATA_W-1];
            cs_n_q     <= 1'b0;
            busy_q     <= 1'b1;
            div_q      <= DIV_LAST;
            state_q    <= ST_SETUP;
          end
        end

        ST_SETUP, ST_LOW: begin
          // Rising sclk edge: sample miso as we enter HIGH.
          if (phase_end) begin
            sclk_q     <= 1'b1;
            rx_shift_q <= {rx_shift_q[DATA_W-2:0], miso};
            state_q    <= ST_HIGH;
          end
        end

        ST_HIGH: begin
          if (phase_end) begin
            sclk_q <= 1'b0;
            if (cnt_zero) begin
              fin_hold_q <= 1'b0;
              state_q    <= ST_FINISH;
            end else begin
              tx_shift_q <= tx_shift_q << 1;
              mosi_q     <= tx_shift_q[DATA_W-2];
              state_q    <= ST_LOW;
            end
          end
        end

        ST_FINISH: begin
          if (phase_end) begin
            if (!fin_hold_q) begin
              fin_hold_q <= 1'b1;
            end else begin
              cs_n_q    <= 1'b1;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              rx_data_q <= rx_shift_q;
              state_q   <= ST_IDLE;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl: an 8-bit/CLK_DIV=2 instance and a 4-bit/CLK_DIV=1
// instance share clk and rst. Outputs are sampled on the negedge; inputs are driven
// right after sampling so they settle well before the next posedge.
module tb_spi_xfer_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       start8, busy8, done8, sclk8, mosi8, miso8, cs8;
  logic [7:0] tx8, rx8;
  logic       loop8, tie8;
  assign miso8 = loop8 ? mosi8 : tie8;

  logic       start4, busy4, done4, sclk4, mosi4, miso4, cs4;
  logic [3:0] tx4, rx4;
  assign miso4 = mosi4;

  spi_xfer_ctrl #(.DATA_W(8), .CLK_DIV(2)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .tx_data(tx8), .rx_data(rx8),
    .busy(busy8), .done(done8), .sclk(sclk8), .mosi(mosi8), .miso(miso8), .cs_n(cs8)
  );

  spi_xfer_ctrl #(.DATA_W(4), .CLK_DIV(1)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .tx_data(tx4), .rx_data(rx4),
    .busy(busy4), .done(done4), .sclk(sclk4), .mosi(mosi4), .miso(miso4), .cs_n(cs4)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Measurements from one run8 window (k = negedges after the accept posedge).
  int         m_done1, m_done2, m_ndone, m_cslow, m_rises, m_mosi1, m_gap;
  logic [7:0] m_rx1, m_rx2, m_snap_rx;
  logic       m_snap_sclk, m_snap_cs, m_snap_busy;

  // Start a transfer of w1 on the 8-bit instance, then observe for 'window' cycles.
  // w2 is driven on tx_data after the accept edge; hold keeps start high;
  // inj_a/inj_b pulse start with 8'h3C; rst_at pulses rst (negative = never).
  task automatic run8(input logic [7:0] w1, input logic [7:0] w2, input bit hold,
                      input int inj_a, input int inj_b, input int rst_at, input int window);
    logic prev_sclk;
    m_done1 = -1; m_done2 = -1; m_ndone = 0; m_cslow = 0; m_rises = 0;
    m_mosi1 = 0;  m_gap = 0;    m_rx1 = 'x;  m_rx2 = 'x;
    @(negedge clk);
    start8 = 1'b1;
    tx8    = w1;
    prev_sclk = sclk8;
    for (int k = 1; k <= window; k++) begin
      @(negedge clk);
      if (done8) begin
        m_ndone++;
        if (m_ndone == 1) begin
          m_done1 = k; m_rx1 = rx8;
        end else if (m_ndone == 2) begin
          m_done2 = k; m_rx2 = rx8;
        end
      end
      if (m_ndone == 0 && !cs8) m_cslow++;
      if (m_ndone == 0 && sclk8 && !prev_sclk) m_rises++;
      if (m_ndone == 0 && mosi8) m_mosi1++;
      if (m_ndone == 1 && cs8) m_gap++;
      prev_sclk = sclk8;
      if (k == rst_at + 1) begin
        m_snap_sclk = sclk8; m_snap_cs = cs8; m_snap_busy = busy8; m_snap_rx = rx8;
      end
      start8 = hold || (k == inj_a) || (k == inj_b);
      tx8    = ((k == inj_a) || (k == inj_b)) ? 8'h3C : w2;
      rst    = (k == rst_at);
    end
    start8 = 1'b0;
    rst    = 1'b0;
  endtask

  int         d4, r1, r2;
  logic [3:0] rx4_at_done;
  logic       prev4;

  initial begin
    rst = 1'b1; start8 = 1'b0; tx8 = '0; start4 = 1'b0; tx4 = '0;
    loop8 = 1'b1; tie8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state.
    check("rst_sclk",  sclk8, 1'b0);
    check("rst_cs_n",  cs8,   1'b1);
    check("rst_mosi",  mosi8, 1'b0);
    check("rst_busy",  busy8, 1'b0);
    check("rst_done",  done8, 1'b0);
    check("rst_rx",    rx8,   8'h00);
    check("rst4_cs_n", cs4,   1'b1);
    check("rst4_sclk", sclk4, 1'b0);

    // 1: loopback A5.
    loop8 = 1'b1;
    run8(8'hA5, 8'hA5, 1'b0, -1, -1, -1, 45);
    check("t1_rx",     m_rx1,   8'hA5);
    check("t1_done_k", m_done1, 37);
    check("t1_ndone",  m_ndone, 1);
    check("t1_rises",  m_rises, 8);

    // 2: miso tied high, tx 00.
    loop8 = 1'b0; tie8 = 1'b1;
    run8(8'h00, 8'h00, 1'b0, -1, -1, -1, 45);
    check("t2_mosi_ones", m_mosi1, 0);
    check("t2_rx",        m_rx1,   8'hFF);
    check("t2_cs_low",    m_cslow, 36);

    // 3: start pulses while busy are ignored.
    loop8 = 1'b1;
    run8(8'hA5, 8'hA5, 1'b0, 5, 20, -1, 45);
    check("t3_ndone",  m_ndone, 1);
    check("t3_rx",     m_rx1,   8'hA5);
    check("t3_done_k", m_done1, 37);

    // 4: reset mid-transfer, then a clean transfer.
    run8(8'h5A, 8'h5A, 1'b0, -1, -1, 10, 45);
    check("t4_sclk",  m_snap_sclk, 1'b0);
    check("t4_cs_n",  m_snap_cs,   1'b1);
    check("t4_busy",  m_snap_busy, 1'b0);
    check("t4_rx",    m_snap_rx,   8'h00);
    check("t4_ndone", m_ndone,     0);
    run8(8'hA5, 8'hA5, 1'b0, -1, -1, -1, 45);
    check("t4_clean_rx",     m_rx1,   8'hA5);
    check("t4_clean_done_k", m_done1, 37);

    // 5: start held high, back-to-back 81 then 7E.
    run8(8'h81, 8'h7E, 1'b1, -1, -1, -1, 80);
    check("t5_rx1",     m_rx1,             8'h81);
    check("t5_rx2",     m_rx2,             8'h7E);
    check("t5_spacing", m_done2 - m_done1, 37);
    check("t5_gap",     (m_gap >= 1),      1'b1);
    // A third word was accepted in the second done cycle; clear it.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;

    // 6: DATA_W=4, CLK_DIV=1, loopback 9.
    @(negedge clk);
    start4 = 1'b1; tx4 = 4'h9;
    d4 = -1; r1 = -1; r2 = -1; rx4_at_done = 'x;
    prev4 = sclk4;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (done4 && d4 < 0) begin
        d4 = k; rx4_at_done = rx4;
      end
      if (sclk4 && !prev4) begin
        if (r1 < 0) r1 = k;
        else if (r2 < 0) r2 = k;
      end
      prev4  = sclk4;
      start4 = 1'b0;
    end
    check("t6_done_k",      d4,          11);
    check("t6_sclk_period", r2 - r1,     2);
    check("t6_rx",          rx4_at_done, 4'h9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
